csr_initiator: RTL and testbench
================================

CSR_INITIATOR -- requirements
Module: csr_initiator

Interface
REQ-001 Parameter RD_LAT, default 1: cycles from the csr_sel issue cycle to the csr_rdata sample cycle; range 1..4.
REQ-002 Parameter MAX_ADDR, default 16'h001f: highest legal CSR select value.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  request pending.
REQ-006 req_ready  output  1  initiator can accept a request.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  16  CSR select.
REQ-009 req_wdata  input  32  write data.
REQ-010 rsp_valid  output  1  response pending.
REQ-011 rsp_ready  input  1  consumer accepts the response.
REQ-012 rsp_rdata  output  32  read data; 0 for writes and errors.
REQ-013 rsp_err  output  1  request address exceeded MAX_ADDR.
REQ-014 csr_we  output  1  write enable to the CSR target.
REQ-015 csr_sel  output  16  select to the CSR target.
REQ-016 csr_wdata  output  32  write data to the CSR target.
REQ-017 csr_rdata  input  32  read data from the CSR target (combinational off the target's registered select).
REQ-018 txn_count  output  16  count of completed response handshakes.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT and RESP; one request in flight at most.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid && req_ready.
REQ-021 Accept with req_addr <= MAX_ADDR: IDLE->ISSUE; addr, write flag and wdata are latched.
REQ-022 Accept with req_addr > MAX_ADDR: IDLE->RESP directly; no bus cycle (csr_we stays 0); rsp_err=1, rsp_rdata=0.
REQ-023 ISSUE lasts exactly 1 cycle: csr_sel=addr, csr_wdata=wdata, csr_we=write flag; then ISSUE->WAIT.
REQ-024 Outside ISSUE: csr_we=0, csr_sel=0, csr_wdata=0 (all registered outputs, no combinational path from req_*).
REQ-025 WAIT lasts exactly RD_LAT cycles; on a read, csr_rdata is captured on the last WAIT cycle; then WAIT->RESP.
REQ-026 Writes SHALL also traverse WAIT, so a following read observes the written value.
REQ-027 RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready; on handshake RESP->IDLE.
REQ-028 Minimum request-to-request spacing: 3+RD_LAT cycles (accept, ISSUE, WAIT x RD_LAT, RESP with rsp_ready=1).
REQ-029 txn_count SHALL increment by 1 on each rsp handshake (errors included); 16'hffff wraps to 16'h0000.
REQ-030 req_valid while not in IDLE SHALL be ignored (not latched).

Reset
REQ-031 rst_n=0 at a posedge: state=IDLE, req_ready=1 (after reset), rsp_valid=0, rsp_rdata=0, rsp_err=0, csr_we=0, csr_sel=0, csr_wdata=0, txn_count=0.
REQ-032 Reset in any state SHALL abandon the in-flight request with no response and no further csr_we pulse.
REQ-033 rst_n dominates a same-cycle request handshake (request dropped).

Verification (target: 32-entry CSR file; 0x00-0x0f writable, 0x10-0x1f constant)
REQ-034 Read 0x0010 after reset -> single ISSUE cycle with csr_sel=0x0010, csr_we=0; rsp_rdata=0x33675230, rsp_err=0, rsp_valid 3 cycles after accept (RD_LAT=1).
REQ-035 Write 0x0003 data 0xdeadbeef, then read 0x0003 -> exactly one csr_we pulse; read returns 0xdeadbeef; txn_count=2.
REQ-036 Read 0x0020 -> no csr_sel/csr_we activity; rsp_err=1, rsp_rdata=0, rsp_valid 1 cycle after accept.
REQ-037 Read 0x0000 with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata=0xe172d365 held stable; req_ready=0 throughout; IDLE 1 cycle after handshake.
REQ-038 rst_n=0 during WAIT of a write to 0x0005 -> all outputs reset next cycle, no response; subsequent read of 0x0005 returns the pre-write value 0xb07d34ad.
REQ-039 Preload txn_count path with 65536 completed transactions -> txn_count wraps to 0; RD_LAT=3 run shows 6-cycle spacing.

Source files
------------

// File: rtl/csr_initiator.sv
// rtl/csr_initiator.sv - single-outstanding CSR bus initiator with fixed-latency read capture
module csr_initiator #(
  parameter int          RD_LAT   = 1,
  parameter logic [15:0] MAX_ADDR = 16'h001f
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        csr_we,
  output logic [15:0] csr_sel,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic [15:0] txn_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  lat_q, lat_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        csr_we_q, csr_we_d;
  logic [15:0] csr_sel_q, csr_sel_d;
  logic [31:0] csr_wdata_q, csr_wdata_d;
  logic [15:0] txn_count_q, txn_count_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      lat_q       <= 2'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      csr_we_q    <= 1'b0;
      csr_sel_q   <= 16'd0;
      csr_wdata_q <= 32'd0;
      txn_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      lat_q       <= lat_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      csr_we_q    <= csr_we_d;
      csr_sel_q   <= csr_sel_d;
      csr_wdata_q <= csr_wdata_d;
      txn_count_q <= txn_count_d;
    end
  end

  // Bus outputs default to idle every cycle, so they are only non-zero during ISSUE.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    lat_d       = lat_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    csr_we_d    = 1'b0;
    csr_sel_d   = 16'd0;
    csr_wdata_d = 32'd0;
    txn_count_d = txn_count_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rsp_rdata_d = 32'd0;
          if (req_addr > MAX_ADDR) begin
            rsp_err_d = 1'b1;
            state_d   = S_RESP;
          end else begin
            rsp_err_d   = 1'b0;
            write_d     = req_write;
            csr_we_d    = req_write;
            csr_sel_d   = req_addr;
            csr_wdata_d = req_wdata;
            state_d     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        lat_d   = 2'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          if (!write_q) begin
            rsp_rdata_d = csr_rdata;
          end
          state_d = S_RESP;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          txn_count_d = txn_count_q + 16'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign csr_we    = csr_we_q;
  assign csr_sel   = csr_sel_q;
  assign csr_wdata = csr_wdata_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_csr_initiator.sv
// tb/tb_csr_initiator.sv - directed bench for csr_initiator with a 32-entry CSR file model
module tb_csr_initiator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid_a = 1'b0, req_write_a = 1'b0, rsp_ready_a = 1'b1;
  logic [15:0] req_addr_a = 16'd0;
  logic [31:0] req_wdata_a = 32'd0;
  logic        req_ready_a, rsp_valid_a, rsp_err_a, csr_we_a;
  logic [31:0] rsp_rdata_a, csr_wdata_a, csr_rdata_a;
  logic [15:0] csr_sel_a, txn_count_a;

  logic        req_valid_b = 1'b0, req_write_b = 1'b0, rsp_ready_b = 1'b1;
  logic [15:0] req_addr_b = 16'd0;
  logic [31:0] req_wdata_b = 32'd0;
  logic        req_ready_b, rsp_valid_b, rsp_err_b, csr_we_b;
  logic [31:0] rsp_rdata_b, csr_wdata_b, csr_rdata_b;
  logic [15:0] csr_sel_b, txn_count_b;

  csr_initiator #(.RD_LAT(1), .MAX_ADDR(16'h001f)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write_a),
    .req_addr(req_addr_a), .req_wdata(req_wdata_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
    .csr_we(csr_we_a), .csr_sel(csr_sel_a), .csr_wdata(csr_wdata_a), .csr_rdata(csr_rdata_a),
    .txn_count(txn_count_a)
  );

  csr_initiator #(.RD_LAT(3), .MAX_ADDR(16'h001f)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .csr_we(csr_we_b), .csr_sel(csr_sel_b), .csr_wdata(csr_wdata_b), .csr_rdata(csr_rdata_b),
    .txn_count(txn_count_b)
  );

  // CSR file targets: select/write pipelined RD_LAT stages, writes land at the end of WAIT
  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  logic        we_pa;
  logic [15:0] sel_pa;
  logic [31:0] wd_pa;
  logic        we_pb [3];
  logic [15:0] sel_pb [3];
  logic [31:0] wd_pb [3];

  function automatic logic [31:0] init_val(input int i);
    case (i)
      0:       return 32'he172d365;
      5:       return 32'hb07d34ad;
      16:      return 32'h33675230;
      default: return 32'ha5000000 | 32'(i);
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      we_pa <= 1'b0; sel_pa <= 16'd0; wd_pa <= 32'd0;
    end else begin
      if (we_pa && sel_pa < 16'd16) mem_a[sel_pa[4:0]] <= wd_pa;
      we_pa <= csr_we_a; sel_pa <= csr_sel_a; wd_pa <= csr_wdata_a;
    end
  end
  assign csr_rdata_a = mem_a[sel_pa[4:0]];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        we_pb[k] <= 1'b0; sel_pb[k] <= 16'd0; wd_pb[k] <= 32'd0;
      end
    end else begin
      if (we_pb[2] && sel_pb[2] < 16'd16) mem_b[sel_pb[2][4:0]] <= wd_pb[2];
      we_pb[0] <= csr_we_b; sel_pb[0] <= csr_sel_b; wd_pb[0] <= csr_wdata_b;
      for (int k = 1; k < 3; k++) begin
        we_pb[k] <= we_pb[k-1]; sel_pb[k] <= sel_pb[k-1]; wd_pb[k] <= wd_pb[k-1];
      end
    end
  end
  assign csr_rdata_b = mem_b[sel_pb[2][4:0]];

  int cyc = 0;
  int we_cnt_a = 0;
  int act_cnt_a = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (csr_we_a) we_cnt_a++;
    if (csr_we_a || csr_sel_a != 16'd0) act_cnt_a++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          t_lat;
  logic [31:0] t_rdata;
  logic        t_err;
  logic [15:0] t_sel1;
  logic        t_we1;

  task automatic req_a(input logic wr, input logic [15:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_valid_a = 1'b1; req_write_a = wr; req_addr_a = addr; req_wdata_a = wd; rsp_ready_a = 1'b1;
    @(negedge clk);
    req_valid_a = 1'b0;
    t_sel1 = csr_sel_a; t_we1 = csr_we_a; t_lat = 1;
    while (!rsp_valid_a && t_lat < 20) begin
      @(negedge clk);
      t_lat++;
    end
    t_rdata = rsp_rdata_a; t_err = rsp_err_a;
    @(negedge clk);
  endtask

  int   snap;
  logic ok;
  int   acc1, acc2;
  logic [31:0] rd_b;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = init_val(i);
      mem_b[i] = init_val(i);
    end

    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready_a), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
    check("rst_rsp_rdata", rsp_rdata_a, 32'd0);
    check("rst_rsp_err", 32'(rsp_err_a), 32'd0);
    check("rst_csr_bus", {15'd0, csr_we_a, csr_sel_a} | csr_wdata_a, 32'd0);
    check("rst_txn", 32'(txn_count_a), 32'd0);
    rst_n = 1'b1;

    req_a(1'b0, 16'h0010, 32'd0);
    check("rd10_sel", 32'(t_sel1), 32'h0010);
    check("rd10_we", 32'(t_we1), 32'd0);
    check("rd10_lat", 32'(t_lat), 32'd3);
    check("rd10_data", t_rdata, 32'h33675230);
    check("rd10_err", 32'(t_err), 32'd0);

    snap = we_cnt_a;
    req_a(1'b1, 16'h0003, 32'hdeadbeef);
    check("wr03_rdata", t_rdata, 32'd0);
    check("wr03_err", 32'(t_err), 32'd0);
    req_a(1'b0, 16'h0003, 32'd0);
    check("rd03_data", t_rdata, 32'hdeadbeef);
    check("wr03_we_pulses", 32'(we_cnt_a - snap), 32'd1);
    check("txn_after3", 32'(txn_count_a), 32'd3);

    snap = act_cnt_a;
    req_a(1'b0, 16'h0020, 32'd0);
    check("rd20_lat", 32'(t_lat), 32'd1);
    check("rd20_err", 32'(t_err), 32'd1);
    check("rd20_rdata", t_rdata, 32'd0);
    check("rd20_bus_idle", 32'(act_cnt_a - snap), 32'd0);

    req_a(1'b0, 16'h001f, 32'd0);
    check("rd1f_err", 32'(t_err), 32'd0);
    check("rd1f_data", t_rdata, 32'ha500001f);

    // Read 0x0000 with a 5-cycle stall; a stray request during the stall must be ignored
    snap = act_cnt_a;
    @(negedge clk);
    req_valid_a = 1'b1; req_write_a = 1'b0; req_addr_a = 16'h0000; rsp_ready_a = 1'b0;
    @(negedge clk);
    req_valid_a = 1'b0;
    t_lat = 1;
    while (!rsp_valid_a && t_lat < 20) begin
      @(negedge clk);
      t_lat++;
    end
    check("rd00_lat", 32'(t_lat), 32'd3);
    ok = 1'b1;
    req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 16'h0003; req_wdata_a = 32'h11111111;
    for (int i = 0; i < 5; i++) begin
      if (!rsp_valid_a || rsp_rdata_a !== 32'he172d365 || req_ready_a) ok = 1'b0;
      @(negedge clk);
    end
    check("rd00_stall_stable", 32'(ok), 32'd1);
    check("rd00_data", rsp_rdata_a, 32'he172d365);
    req_valid_a = 1'b0;
    rsp_ready_a = 1'b1;
    @(negedge clk);
    check("rd00_idle_req_ready", 32'(req_ready_a), 32'd1);
    check("rd00_idle_rsp_valid", 32'(rsp_valid_a), 32'd0);
    @(negedge clk);
    check("rd00_stray_ignored", 32'(act_cnt_a - snap), 32'd0);
    check("txn_after6", 32'(txn_count_a), 32'd6);

    // Reset during WAIT of a write to 0x0005
    req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 16'h0005; req_wdata_a = 32'h12345678;
    @(negedge clk);
    req_valid_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("wait_rst_req_ready", 32'(req_ready_a), 32'd1);
    check("wait_rst_outputs", {29'd0, rsp_valid_a, rsp_err_a, csr_we_a} | csr_wdata_a | 32'(csr_sel_a), 32'd0);
    check("wait_rst_txn", 32'(txn_count_a), 32'd0);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid_a || csr_we_a) ok = 1'b0;
    end
    check("wait_rst_no_rsp", 32'(ok), 32'd1);
    req_a(1'b0, 16'h0005, 32'd0);
    check("rd05_prewrite", t_rdata, 32'hb07d34ad);

    // Reset wins over a same-cycle handshake
    @(negedge clk);
    rst_n = 1'b0;
    req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 16'h0003; req_wdata_a = 32'h22222222;
    @(negedge clk);
    req_valid_a = 1'b0;
    rst_n = 1'b1;
    check("rst_hs_dropped_bus", {15'd0, csr_we_a, csr_sel_a}, 32'd0);
    check("rst_hs_ready", 32'(req_ready_a), 32'd1);
    @(negedge clk);
    check("rst_hs_no_rsp", 32'(rsp_valid_a), 32'd0);

    // txn_count wrap from a preloaded value
    force dut_a.txn_count_q = 16'hfffe;
    #1;
    release dut_a.txn_count_q;
    check("wrap_preload", 32'(txn_count_a), 32'h0000fffe);
    req_a(1'b0, 16'h0040, 32'd0);
    check("wrap_ffff", 32'(txn_count_a), 32'h0000ffff);
    req_a(1'b0, 16'h0041, 32'd0);
    check("wrap_zero", 32'(txn_count_a), 32'h00000000);

    // RD_LAT=3 back-to-back reads: accept spacing 6
    acc1 = -1; acc2 = -1; rd_b = 32'd0;
    @(negedge clk);
    req_valid_b = 1'b1; req_write_b = 1'b0; req_addr_b = 16'h0010; rsp_ready_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (req_valid_b && req_ready_b) begin
        if (acc1 < 0) acc1 = cyc;
        else if (acc2 < 0) acc2 = cyc;
      end
      if (rsp_valid_b) rd_b = rsp_rdata_b;
      @(negedge clk);
    end
    req_valid_b = 1'b0;
    check("lat3_spacing", 32'(acc2 - acc1), 32'd6);
    check("lat3_rdata", rd_b, 32'h33675230);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
